line_fill_server: RTL and testbench

LINE_FILL_SERVER -- requirements
Module: line_fill_server

---
 rtl/line_fill_server_pkg.sv | 6 +
 rtl/line_fill_server_flop.sv | 15 +
 rtl/line_fill_server_line_assembler.sv | 21 ++
 rtl/line_fill_server.sv | 52 +++++
 tb/tb_line_fill_server.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/line_fill_server_pkg.sv
// line_fill_server_pkg: shared FSM encoding and beat geometry for the line fill path
package line_fill_server_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RESP, HOLD} state_e;
  localparam int BEATS = 4;
  localparam int OFF_W = 3;
endpackage

// File: rtl/line_fill_server_flop.sv
// line_fill_server_flop: width-parameterised flop with asynchronous active-low clear
module line_fill_server_flop #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  // plain register, cleared to zero whenever rst_n is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_o <= '0;
    else q_o <= d_i;
  end
endmodule

// File: rtl/line_fill_server_line_assembler.sv
// line_assembler: collects memory beats into one cache line by beat index
module line_assembler
  import line_fill_server_pkg::*;
#(
  parameter int BEAT_BITS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we_i,
  input  logic [$clog2(BEATS)-1:0]   idx_i,
  input  logic [BEAT_BITS-1:0]       beat_i,
  output logic [BEATS*BEAT_BITS-1:0] line_o
);
  logic [BEATS-1:0][BEAT_BITS-1:0] beats_q;
  // write the incoming beat into its slot; untouched slots keep their value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beats_q <= '0;
    else if (we_i) beats_q[idx_i] <= beat_i;
  end
  assign line_o = beats_q;
endmodule

// File: rtl/line_fill_server.sv
// line_fill_server: turns one icache line miss into four backing-memory beat reads
module line_fill_server
  import line_fill_server_pkg::*;
#(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [58:0]          icache_req_addr,
  input  logic                 icache_req_addr_valid,
  output logic [LINE_BITS-1:0] icache_ack_data,
  output logic                 icache_ack_data_valid,
  output logic [63:0]          mem_req_addr,
  output logic                 mem_req_valid,
  input  logic                 mem_req_retry,
  input  logic [BEAT_BITS-1:0] mem_ack_data,
  input  logic                 mem_ack_valid
);
  localparam int IDX_W = $clog2(BEATS);
  logic [1:0]  state_raw;
  state_e      state_q, state_d;
  logic [2:0]  issue_q, issue_d, collect_q, collect_d;
  logic [58:0] line_q, line_d;
  logic        start, accept, take;
  assign state_q = state_e'(state_raw);
  // counters saturate at BEATS because issue/collect are gated once they reach it
  always_comb begin
    start = state_q == IDLE && icache_req_addr_valid;
    mem_req_valid = state_q == FILL && issue_q < 3'(BEATS);
    mem_req_addr = {line_q, issue_q[IDX_W-1:0], OFF_W'(0)};
    accept = mem_req_valid && !mem_req_retry;
    take = state_q == FILL && collect_q < 3'(BEATS) && mem_ack_valid;
    icache_ack_data_valid = state_q == RESP;
    line_d = start ? icache_req_addr : line_q;
    issue_d = start ? '0 : issue_q + 3'(accept);
    collect_d = start ? '0 : collect_q + 3'(take);
    state_d = start ? FILL
            : (take && collect_q == 3'(BEATS-1)) ? RESP
            : state_q == RESP ? HOLD
            : state_q == HOLD ? IDLE
            : state_q;
  end
  line_fill_server_flop #(.W(2))  u_state   (.clk(clk), .rst_n(reset), .d_i(state_d),   .q_o(state_raw));
  line_fill_server_flop #(.W(3))  u_issue   (.clk(clk), .rst_n(reset), .d_i(issue_d),   .q_o(issue_q));
  line_fill_server_flop #(.W(3))  u_collect (.clk(clk), .rst_n(reset), .d_i(collect_d), .q_o(collect_q));
  line_fill_server_flop #(.W(59)) u_line    (.clk(clk), .rst_n(reset), .d_i(line_d),    .q_o(line_q));
  line_assembler #(.BEAT_BITS(BEAT_BITS)) u_asm (
    .clk(clk), .rst_n(reset), .we_i(take), .idx_i(collect_q[IDX_W-1:0]),
    .beat_i(mem_ack_data), .line_o(icache_ack_data)
  );
endmodule

// File: tb/tb_line_fill_server.sv
// tb_line_fill_server: directed checks of line fills, retry, held requests and reset
module tb_line_fill_server;
  logic         clk = 1'b0;
  logic         reset;
  logic [58:0]  icache_req_addr;
  logic         icache_req_addr_valid;
  logic [255:0] icache_ack_data;
  logic         icache_ack_data_valid;
  logic [63:0]  mem_req_addr;
  logic         mem_req_valid;
  logic         mem_req_retry;
  logic [63:0]  mem_ack_data;
  logic         mem_ack_valid;
  line_fill_server dut (
    .clk(clk), .reset(reset),
    .icache_req_addr(icache_req_addr), .icache_req_addr_valid(icache_req_addr_valid),
    .icache_ack_data(icache_ack_data), .icache_ack_data_valid(icache_ack_data_valid),
    .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid), .mem_req_retry(mem_req_retry),
    .mem_ack_data(mem_ack_data), .mem_ack_valid(mem_ack_valid)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  int cyc, acc_n, pulses, ack_cyc, stable, retry_beat, retry_left;
  logic [3:0]   seed;
  logic         pend;
  logic [63:0]  pend_data, watch_addr;
  logic [63:0]  addr_log [8];
  logic [255:0] ack_line;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  function automatic logic [63:0] pat(input logic [3:0] s, input int k);
    logic [3:0] n;
    n = s + 4'(k);
    return {16{n}};
  endfunction
  function automatic logic [255:0] exp_line(input logic [3:0] s);
    logic [255:0] r;
    for (int k = 0; k < 4; k++) r[64*k +: 64] = pat(s, k);
    return r;
  endfunction
  task automatic tick();
    mem_ack_valid = pend;
    mem_ack_data = pend_data;
    mem_req_retry = mem_req_valid && acc_n == retry_beat && retry_left > 0;
    if (mem_req_retry) retry_left--;
    if (mem_req_valid && mem_req_addr == watch_addr) stable++;
    if (mem_req_valid && !mem_req_retry) begin
      if (acc_n < 8) addr_log[acc_n] = mem_req_addr;
      pend_data = pat(seed, acc_n);
      acc_n++;
      pend = 1'b1;
    end else pend = 1'b0;
    if (icache_ack_data_valid) begin
      pulses++;
      ack_cyc = cyc;
      ack_line = icache_ack_data;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic arm(input logic [58:0] line, input logic [3:0] s, input int rbeat, input int rlen);
    acc_n = 0; pend = 1'b0; pulses = 0; ack_cyc = -1; stable = 0; cyc = 0;
    seed = s; retry_beat = rbeat; retry_left = rlen;
    icache_req_addr = line;
    icache_req_addr_valid = 1'b1;
  endtask
  task automatic do_fill(input logic [58:0] line, input logic [3:0] s, input int rbeat, input int rlen, input int extra);
    arm(line, s, rbeat, rlen);
    for (int i = 0; i < 40 && pulses == 0; i++) tick();
    if (pulses == 0) chk("fill_timeout", 256'(pulses), 256'd1);
    repeat (extra) tick();
    icache_req_addr_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b0;
    icache_req_addr = '0; icache_req_addr_valid = 1'b0;
    mem_req_retry = 1'b0; mem_ack_data = '0; mem_ack_valid = 1'b0;
    pend = 1'b0; pend_data = '0; watch_addr = '1; seed = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack_valid", 256'(icache_ack_data_valid), 256'd0);
    chk("rst_ack_data", icache_ack_data, 256'd0);
    chk("rst_mem_valid", 256'(mem_req_valid), 256'd0);
    chk("rst_mem_addr", 256'(mem_req_addr), 256'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    // single fill, request held through the HOLD cycle
    do_fill(59'hABC, 4'h1, 0, 0, 1);
    chk("f1_addr0", 256'(addr_log[0]), 256'h15780);
    chk("f1_addr1", 256'(addr_log[1]), 256'h15788);
    chk("f1_addr2", 256'(addr_log[2]), 256'h15790);
    chk("f1_addr3", 256'(addr_log[3]), 256'h15798);
    chk("f1_line", ack_line, {64'h4444444444444444, 64'h3333333333333333,
                              64'h2222222222222222, 64'h1111111111111111});
    chk("f1_latency", 256'(ack_cyc), 256'd6);
    repeat (4) tick();
    chk("held_pulses", 256'(pulses), 256'd1);
    chk("held_accepts", 256'(acc_n), 256'd4);
    chk("held_idle_valid", 256'(mem_req_valid), 256'd0);
    // spurious acks while idle
    mem_ack_valid = 1'b1;
    mem_ack_data = '1;
    @(posedge clk);
    #1;
    chk("spur_ack_valid0", 256'(icache_ack_data_valid), 256'd0);
    @(posedge clk);
    #1;
    mem_ack_valid = 1'b0;
    chk("spur_ack_valid1", 256'(icache_ack_data_valid), 256'd0);
    chk("spur_mem_valid", 256'(mem_req_valid), 256'd0);
    chk("spur_line_kept", icache_ack_data, exp_line(4'h1));
    // retry on beat 2 for three cycles
    watch_addr = 64'h50;
    do_fill(59'h2, 4'h5, 2, 3, 0);
    chk("rt_stable", 256'(stable), 256'd4);
    chk("rt_accepts", 256'(acc_n), 256'd4);
    chk("rt_addr2", 256'(addr_log[2]), 256'h50);
    chk("rt_line", ack_line, exp_line(4'h5));
    chk("rt_latency", 256'(ack_cyc), 256'd9);
    // HOLD cycle, then the next request arrives in the first IDLE cycle
    tick();
    watch_addr = '1;
    do_fill(59'h1, 4'h9, 0, 0, 0);
    chk("b2b_addr0", 256'(addr_log[0]), 256'h20);
    chk("b2b_addr1", 256'(addr_log[1]), 256'h28);
    chk("b2b_addr2", 256'(addr_log[2]), 256'h30);
    chk("b2b_addr3", 256'(addr_log[3]), 256'h38);
    chk("b2b_line", ack_line, exp_line(4'h9));
    chk("b2b_latency", 256'(ack_cyc), 256'd6);
    tick();
    tick();
    // reset after two beats have been collected
    arm(59'h3, 4'hD, 0, 0);
    repeat (4) tick();
    reset = 1'b0;
    icache_req_addr_valid = 1'b0;
    mem_ack_valid = 1'b0;
    #2;
    chk("mid_rst_ack_valid", 256'(icache_ack_data_valid), 256'd0);
    chk("mid_rst_ack_data", icache_ack_data, 256'd0);
    chk("mid_rst_mem_valid", 256'(mem_req_valid), 256'd0);
    chk("mid_rst_mem_addr", 256'(mem_req_addr), 256'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_ack_valid = 1'b1;
    mem_ack_data = 64'hDEADBEEFDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    mem_ack_valid = 1'b0;
    chk("stray_ack_valid", 256'(icache_ack_data_valid), 256'd0);
    chk("stray_mem_valid", 256'(mem_req_valid), 256'd0);
    chk("stray_ack_data", icache_ack_data, 256'd0);
    do_fill(59'h3, 4'h2, 0, 0, 0);
    chk("clean_addr0", 256'(addr_log[0]), 256'h60);
    chk("clean_line", ack_line, exp_line(4'h2));
    chk("clean_latency", 256'(ack_cyc), 256'd6);
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
